sq_retire_writer: RTL

- Dcache-side receiver for retired stores from the store queue.
- Buffers up to N_WAY retired store packets per cycle in a FIFO and drains them one at a time to the memory bus with a request/response handshake.
- Returns one completion (valid + store_pos) per drained store. The store queue uses that completion to free the entry and bump its empty count.

---
 rtl/sq_retire_writer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sq_retire_writer.sv
// Retired-store write buffer: accepts up to N_WAY retired stores per cycle
// into a circular FIFO and drains them one at a time to the memory bus,
// returning a completion (valid + store_pos) for each accepted request.
module sq_retire_writer #(
  parameter int unsigned N_WAY = 2,
  parameter int unsigned N_SQ  = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [N_WAY-1:0]                   ret_valid,
  input  logic [N_WAY*XLEN-1:0]              ret_addr,
  input  logic [N_WAY*XLEN-1:0]              ret_data,
  input  logic [N_WAY*2-1:0]                 ret_size,
  input  logic [N_WAY*($clog2(N_SQ)+1)-1:0]  ret_store_pos,
  output logic [$clog2(N_WAY):0]             free_slots,
  output logic [1:0]                         proc2mem_command,
  output logic [XLEN-1:0]                    proc2mem_addr,
  output logic [63:0]                        proc2mem_data,
  output logic [1:0]                         proc2mem_size,
  input  logic [3:0]                         mem2proc_response,
  output logic                               done_valid,
  output logic [$clog2(N_SQ):0]              done_store_pos,
  output logic                               overflow_err
);

  localparam int unsigned PW = $clog2(N_SQ) + 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FW = $clog2(N_WAY) + 1;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   head_q, head_d;
  logic [IW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            done_valid_q, done_valid_d;
  logic [PW-1:0]   done_pos_q, done_pos_d;
  logic            ovf_q, ovf_d;

  logic [XLEN-1:0] addr_q [DEPTH];
  logic [63:0]     data_q [DEPTH];
  logic [1:0]      size_q [DEPTH];
  logic [PW-1:0]   pos_q  [DEPTH];

  int unsigned     free_n;
  int unsigned     acc_n;
  logic            ovf_hit;
  logic [N_WAY-1:0] acc_lane;
  logic [IW-1:0]   wr_idx [N_WAY];
  logic            pop;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                             input int unsigned   off);
    return IW'((32'(base) + off) % DEPTH);
  endfunction

  function automatic logic [63:0] mask_data(input logic [XLEN-1:0] d,
                                            input logic [1:0]      sz);
    logic [63:0] m;
    m = '0;
    case (sz)
      2'd0:    m[7:0]  = d[7:0];
      2'd1:    m[15:0] = d[15:0];
      default: m[31:0] = d[31:0];
    endcase
    return m;
  endfunction

  // Lane acceptance against entries free at the start of the cycle; accepted
  // lanes are packed at tail by their rank among accepted lanes.
  always_comb begin
    free_n   = DEPTH - 32'(count_q);
    acc_n    = 0;
    ovf_hit  = 1'b0;
    acc_lane = '0;
    for (int unsigned i = 0; i < N_WAY; i++) begin
      wr_idx[i] = wrap_add(tail_q, acc_n);
      if (ret_valid[i]) begin
        if (i < free_n) begin
          acc_lane[i] = 1'b1;
          acc_n       = acc_n + 1;
        end else begin
          ovf_hit = 1'b1;
        end
      end
    end
  end

  assign free_slots = (free_n < N_WAY) ? FW'(free_n) : FW'(N_WAY);

  // Buffer storage write for accepted lanes (no reset: contents are qualified by count).
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < N_WAY; i++) begin
      if (acc_lane[i]) begin
        addr_q[wr_idx[i]] <= ret_addr[i*XLEN +: XLEN];
        data_q[wr_idx[i]] <= mask_data(ret_data[i*XLEN +: XLEN], ret_size[i*2 +: 2]);
        size_q[wr_idx[i]] <= ret_size[i*2 +: 2];
        pos_q[wr_idx[i]]  <= ret_store_pos[i*PW +: PW];
      end
    end
  end

  // Next-state: pointers, occupancy, FSM and completion.
  always_comb begin
    pop          = (state_q == ST_ISSUE) && (mem2proc_response != 4'd0);
    head_d       = pop ? wrap_add(head_q, 1) : head_q;
    tail_d       = wrap_add(tail_q, acc_n);
    count_d      = CW'(32'(count_q) + acc_n - 32'(pop));
    ovf_d        = ovf_q | ovf_hit;
    done_valid_d = pop;
    done_pos_d   = pop ? pos_q[head_q] : done_pos_q;
    state_d      = state_q;
    case (state_q)
      ST_IDLE:  if (count_q != '0) state_d = ST_ISSUE;
      ST_ISSUE: if (pop) state_d = (count_d != '0) ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Memory request driven straight from the head entry while issuing.
  always_comb begin
    proc2mem_command = CMD_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    proc2mem_size    = '0;
    if (state_q == ST_ISSUE) begin
      proc2mem_command = CMD_STORE;
      proc2mem_addr    = addr_q[head_q];
      proc2mem_data    = data_q[head_q];
      proc2mem_size    = size_q[head_q];
    end
  end

  // Control state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      done_valid_q <= 1'b0;
      done_pos_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      done_valid_q <= done_valid_d;
      done_pos_q   <= done_pos_d;
      ovf_q        <= ovf_d;
    end
  end

  assign done_valid     = done_valid_q;
  assign done_store_pos = done_pos_q;
  assign overflow_err   = ovf_q;

endmodule
